idli_mem_arb_m: RTL

Arbiter and sequencer for the single external SQI memory, shared between instruction fetch (FE, read-only) and the execution unit (EX, loads and stores).
- Grants one requester at a time using round-robin.
- Runs a full SQI transaction: command, 16b address, dummy cycles for reads, then one 16b data word moved as four nibbles.
- Data nibbles stream low nibble first, so they line up with the EX serial ALU nibble order.

---
 rtl/idli_mem_arb_m_pkg.sv | 34 +++
 rtl/idli_mem_arb_m_if.sv | 50 +++++
 rtl/idli_mem_arb_m.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/idli_mem_arb_m_pkg.sv
// Shared types and constants for the idli memory arbiter.
//
// Contents:
//   sqi_data_t       one 4-bit SQI bus nibble
//   mem_arb_state_t  arbiter sequencer states
//   mem_owner_t      which requester owns the memory (FE or EX)
//   SQI_CMD_RD/WR    SQI command bytes
//   sqi_nibble()     selects one nibble of a 16-bit word
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA
  } mem_arb_state_t;

  typedef enum logic {
    FE,
    EX
  } mem_owner_t;

  localparam logic [7:0] SQI_CMD_RD = 8'h03;
  localparam logic [7:0] SQI_CMD_WR = 8'h02;

  // Nibble 0 is bits [3:0] and nibble 3 is bits [15:12].
  function automatic sqi_data_t sqi_nibble(input logic [15:0] word, input logic [1:0] sel);
    return word[{sel, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/idli_mem_arb_m_if.sv
// Bus bundle between the arbiter, its two requesters and the SQI pads.
//
// Signals:
//   fe_req/fe_addr            FE read request and address
//   fe_gnt                    FE grant pulse
//   fe_data/fe_data_vld       FE read nibble stream
//   ex_req/ex_wr/ex_addr      EX request, write flag and address
//   ex_wr_data                EX write nibble (sampled while ex_wr_rdy)
//   ex_gnt                    EX grant pulse
//   ex_wr_rdy                 EX must present its next write nibble
//   ex_rd_data/ex_rd_vld      EX read nibble stream
//   sqi_cs_n/sqi_oe/sqi_out   pad chip select, output enable, output nibble
//   sqi_in                    pad input nibble
// Modports: slave = arbiter side, master = requesters plus pads.
interface idli_mem_arb_m_if;
  import idli_pkg::*;

  logic      fe_req;
  logic [15:0] fe_addr;
  logic      fe_gnt;
  sqi_data_t fe_data;
  logic      fe_data_vld;

  logic      ex_req;
  logic      ex_wr;
  logic [15:0] ex_addr;
  sqi_data_t ex_wr_data;
  logic      ex_gnt;
  logic      ex_wr_rdy;
  sqi_data_t ex_rd_data;
  logic      ex_rd_vld;

  logic      sqi_cs_n;
  logic      sqi_oe;
  sqi_data_t sqi_out;
  sqi_data_t sqi_in;

  modport slave (
    input  fe_req, fe_addr, ex_req, ex_wr, ex_addr, ex_wr_data, sqi_in,
    output fe_gnt, fe_data, fe_data_vld, ex_gnt, ex_wr_rdy, ex_rd_data, ex_rd_vld,
           sqi_cs_n, sqi_oe, sqi_out
  );

  modport master (
    output fe_req, fe_addr, ex_req, ex_wr, ex_addr, ex_wr_data, sqi_in,
    input  fe_gnt, fe_data, fe_data_vld, ex_gnt, ex_wr_rdy, ex_rd_data, ex_rd_vld,
           sqi_cs_n, sqi_oe, sqi_out
  );

endinterface

// File: rtl/idli_mem_arb_m.sv
// Round-robin arbiter and SQI transaction sequencer for the single external
// memory shared by instruction fetch (FE, reads) and execute (EX, reads and
// writes). Each transaction is: 2 command nibbles, 4 address nibbles (MSN
// first), DUMMY_CYCLES turnaround cycles for reads, then 4 data nibbles
// streamed low nibble first.
//
// Ports:
//   i_arb_gck    clock
//   i_arb_rst_n  asynchronous active-low reset
//   bus          idli_mem_arb_m_if.slave (requesters and SQI pads)
// Parameters:
//   DUMMY_CYCLES read turnaround cycles (1-3)
//   RD_CMD       SQI read command byte
//   WR_CMD       SQI write command byte
module idli_mem_arb_m
  import idli_pkg::*;
#(
  parameter int         DUMMY_CYCLES = 2,
  parameter logic [7:0] RD_CMD       = SQI_CMD_RD,
  parameter logic [7:0] WR_CMD       = SQI_CMD_WR
) (
  input  logic           i_arb_gck,
  input  logic           i_arb_rst_n,
  idli_mem_arb_m_if.slave bus
);

  localparam logic [1:0] DUMMY_LAST = 2'(DUMMY_CYCLES - 1);

  mem_arb_state_t state, state_nxt;
  logic [1:0]     cnt, cnt_nxt;
  mem_owner_t     owner, last_gnt, winner;
  logic           wr, wr_nxt;
  logic [15:0]    addr, addr_nxt;

  logic           cs_n_q, cs_n_nxt;
  logic           oe_q, oe_nxt;
  sqi_data_t      out_q, out_nxt;

  logic           any_req, grant;
  logic           rd_phase, wr_phase;
  logic [7:0]     cmd_nxt;

  // On a tie the requester that did not win last time gets the memory.
  always_comb begin
    any_req = bus.fe_req | bus.ex_req;
    if (bus.fe_req && bus.ex_req) begin
      winner = (last_gnt == FE) ? EX : FE;
    end else if (bus.ex_req) begin
      winner = EX;
    end else begin
      winner = FE;
    end
    grant = (state == IDLE) && any_req;
  end

  assign bus.fe_gnt = grant && (winner == FE);
  assign bus.ex_gnt = grant && (winner == EX);

  // Sequencer next state, plus the pad values for the cycle after the edge
  // so cs_n/oe/sqi_out come straight out of flops.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 2'd1;
    wr_nxt    = wr;
    addr_nxt  = addr;

    case (state)
      IDLE: begin
        cnt_nxt = 2'd0;
        if (grant) begin
          state_nxt = CMD;
          wr_nxt    = (winner == EX) && bus.ex_wr;
          addr_nxt  = (winner == EX) ? bus.ex_addr : bus.fe_addr;
        end
      end
      CMD: begin
        if (cnt == 2'd1) begin
          state_nxt = ADDR;
          cnt_nxt   = 2'd0;
        end
      end
      ADDR: begin
        if (cnt == 2'd3) begin
          state_nxt = wr ? DATA : DUMMY;
          cnt_nxt   = 2'd0;
        end
      end
      DUMMY: begin
        if (cnt == DUMMY_LAST) begin
          state_nxt = DATA;
          cnt_nxt   = 2'd0;
        end
      end
      DATA: begin
        if (cnt == 2'd3) begin
          state_nxt = IDLE;
          cnt_nxt   = 2'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end
    endcase

    cmd_nxt  = wr_nxt ? WR_CMD : RD_CMD;
    cs_n_nxt = (state_nxt == IDLE);
    oe_nxt   = 1'b0;
    out_nxt  = '0;
    case (state_nxt)
      CMD: begin
        oe_nxt  = 1'b1;
        out_nxt = sqi_nibble({8'h00, cmd_nxt}, {1'b0, ~cnt_nxt[0]});
      end
      ADDR: begin
        oe_nxt  = 1'b1;
        out_nxt = sqi_nibble(addr_nxt, ~cnt_nxt);
      end
      DATA: begin
        oe_nxt  = wr_nxt;
      end
      default: begin
        oe_nxt  = 1'b0;
      end
    endcase
  end

  // last_gnt resets to FE so EX wins the first tie after reset.
  always_ff @(posedge i_arb_gck or negedge i_arb_rst_n) begin
    if (!i_arb_rst_n) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      owner    <= FE;
      last_gnt <= FE;
      wr       <= 1'b0;
      addr     <= '0;
      cs_n_q   <= 1'b1;
      oe_q     <= 1'b0;
      out_q    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wr       <= wr_nxt;
      addr     <= addr_nxt;
      cs_n_q   <= cs_n_nxt;
      oe_q     <= oe_nxt;
      out_q    <= out_nxt;
      if (grant) begin
        owner    <= winner;
        last_gnt <= winner;
      end
    end
  end

  assign rd_phase = (state == DATA) && !wr;
  assign wr_phase = (state == DATA) && wr;

  // Read data flows straight from the pads to the owner; everything else is
  // held at zero so nothing undefined reaches the requesters or the pads.
  assign bus.fe_data_vld = rd_phase && (owner == FE);
  assign bus.fe_data     = bus.fe_data_vld ? bus.sqi_in : '0;
  assign bus.ex_rd_vld   = rd_phase && (owner == EX);
  assign bus.ex_rd_data  = bus.ex_rd_vld ? bus.sqi_in : '0;
  assign bus.ex_wr_rdy   = wr_phase;

  assign bus.sqi_cs_n = cs_n_q;
  assign bus.sqi_oe   = oe_q;
  assign bus.sqi_out  = wr_phase ? bus.ex_wr_data : out_q;

  a_fe_no_wr_rdy: assert property (@(posedge i_arb_gck) disable iff (!i_arb_rst_n)
    !(bus.ex_wr_rdy && (owner == FE)));

  a_gnt_onehot: assert property (@(posedge i_arb_gck) disable iff (!i_arb_rst_n)
    $onehot0({bus.fe_gnt, bus.ex_gnt}));

  a_gnt_in_idle: assert property (@(posedge i_arb_gck) disable iff (!i_arb_rst_n)
    (bus.fe_gnt || bus.ex_gnt) |-> (state == IDLE));

  a_cs_oe: assert property (@(posedge i_arb_gck) disable iff (!i_arb_rst_n)
    bus.sqi_cs_n |-> !bus.sqi_oe);

endmodule
